dcache_controller: RTL and testbench

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

---
 rtl/dcache_pkg.sv | 11 +
 rtl/dcache_if.sv | 21 ++
 rtl/dcache_sram.sv | 47 ++++
 rtl/dcache_controller.sv | 111 +++++++++++
 tb/tb_dcache_controller.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry constants and FSM states shared by the direct-mapped data cache
package dcache_pkg;
    localparam int ADDR_W   = 32;
    localparam int WORD_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int NUM_SETS = 16;
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
    localparam int LINE_W   = 256;
    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE} state_e;
endpackage

// File: rtl/dcache_if.sv
// dcache_if: read/write channel between the cache FSM and its tag/state/data array
interface dcache_if #(parameter int IW = 4, parameter int TW = 23, parameter int LW = 256);
    logic [IW-1:0] rd_idx;
    logic          rd_valid;
    logic          rd_dirty;
    logic [TW-1:0] rd_tag;
    logic [LW-1:0] rd_data;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic          wr_dirty;
    logic [TW-1:0] wr_tag;
    logic [LW-1:0] wr_data;
    modport master (
        output rd_idx, wr_en, wr_idx, wr_dirty, wr_tag, wr_data,
        input  rd_valid, rd_dirty, rd_tag, rd_data
    );
    modport slave (
        input  rd_idx, wr_en, wr_idx, wr_dirty, wr_tag, wr_data,
        output rd_valid, rd_dirty, rd_tag, rd_data
    );
endinterface

// File: rtl/dcache_sram.sv
// dcache_sram: per-set valid/dirty/tag/line storage, one write port, combinational read
module dcache_sram #(
    parameter int NUM_SETS = 16,
    parameter int IW       = 4,
    parameter int TW       = 23,
    parameter int LW       = 256
) (
    input  logic     clk_i,
    input  logic     rst_i,
    dcache_if.slave  bus
);
    logic [NUM_SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [TW-1:0]       tag_q  [NUM_SETS];
    logic [LW-1:0]       data_q [NUM_SETS];

    // every write leaves the set valid: both store hits and refills produce a live line
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (bus.wr_en) begin
            valid_d[bus.wr_idx] = 1'b1;
            dirty_d[bus.wr_idx] = bus.wr_dirty;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (bus.wr_en) begin
            tag_q[bus.wr_idx]  <= bus.wr_tag;
            data_q[bus.wr_idx] <= bus.wr_data;
        end
    end

    assign bus.rd_valid = valid_q[bus.rd_idx];
    assign bus.rd_dirty = dirty_q[bus.rd_idx];
    assign bus.rd_tag   = tag_q[bus.rd_idx];
    assign bus.rd_data  = data_q[bus.rd_idx];
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back, write-allocate data cache with blocking miss FSM
module dcache_controller #(
    parameter int NUM_SETS = dcache_pkg::NUM_SETS,
    parameter int LINE_W   = dcache_pkg::LINE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_write_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);
    import dcache_pkg::*;

    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = ADDR_W - OFFSET_W - IW;
    localparam int LA = ADDR_W - OFFSET_W;

    state_e                state_q, state_d;
    logic [LA-1:0]         addr_q, addr_d;
    logic [IW-1:0]         cpu_idx;
    logic [TW-1:0]         cpu_tag;
    logic [OFFSET_W-3:0]   wsel;
    logic                  hit;
    logic [LINE_W-1:0]     merged;
    logic                  unused_lsb;

    dcache_if #(.IW(IW), .TW(TW), .LW(LINE_W)) sif ();

    dcache_sram #(.NUM_SETS(NUM_SETS), .IW(IW), .TW(TW), .LW(LINE_W)) u_sram (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (sif)
    );

    assign unused_lsb = ^cpu_addr_i[1:0];
    assign cpu_idx    = cpu_addr_i[OFFSET_W +: IW];
    assign cpu_tag    = cpu_addr_i[ADDR_W-1 -: TW];
    assign wsel       = cpu_addr_i[OFFSET_W-1:2];
    // outside IDLE the set is addressed by the latched miss line, so a dropped request cannot disturb it
    assign sif.rd_idx = (state_q == IDLE) ? cpu_idx : addr_q[IW-1:0];
    assign hit        = cpu_req_i && state_q == IDLE && sif.rd_valid && sif.rd_tag == cpu_tag;

    always_comb begin
        merged = sif.rd_data;
        merged[wsel*WORD_W +: WORD_W] = cpu_data_i;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        sif.wr_en    = 1'b0;
        sif.wr_idx   = sif.rd_idx;
        sif.wr_dirty = 1'b1;
        sif.wr_tag   = cpu_tag;
        sif.wr_data  = merged;
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        cpu_stall_o  = rst_i && (state_q != IDLE || (cpu_req_i && !hit));
        cpu_data_o   = hit ? sif.rd_data[wsel*WORD_W +: WORD_W] : '0;
        case (state_q)
            IDLE: begin
                sif.wr_en = hit && cpu_write_i;
                if (cpu_req_i && !hit) begin
                    state_d = MISS;
                    addr_d  = cpu_addr_i[ADDR_W-1:OFFSET_W];
                end
            end
            MISS: state_d = (sif.rd_valid && sif.rd_dirty) ? WRITEBACK : REFILL;
            WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = {sif.rd_tag, addr_q[IW-1:0], {OFFSET_W{1'b0}}};
                mem_data_o  = sif.rd_data;
                if (mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_q, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    state_d      = REFILL_DONE;
                    sif.wr_en    = 1'b1;
                    sif.wr_dirty = 1'b0;
                    sif.wr_tag   = addr_q[LA-1 -: TW];
                    sif.wr_data  = mem_data_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed scenarios with a bench-side memory responder and hand-computed results
module tb_dcache_controller;
    import dcache_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req, cpu_write;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         mem_req, mem_write, mem_ack;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;

    int           tests = 0;
    int           fails = 0;
    int           nreq;
    logic         req_wr   [4];
    logic [31:0]  req_addr [4];
    logic [255:0] req_data [4];
    int           st;
    logic [31:0]  rd;

    dcache_controller dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .cpu_req_i   (cpu_req),
        .cpu_write_i (cpu_write),
        .cpu_addr_i  (cpu_addr),
        .cpu_data_i  (cpu_wdata),
        .cpu_data_o  (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .mem_req_o   (mem_req),
        .mem_write_o (mem_write),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_wdata),
        .mem_data_i  (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // refill pattern: each word carries its own byte address tagged with A5A5
    function automatic logic [255:0] mkline(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = {16'hA5A5, a[15:5], i[2:0], 2'b00};
        return l;
    endfunction

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input int dly,
                          input logic drop, output int stalls, output logic [31:0] data);
        int  waitc;
        bit  fresh;
        stalls = 0;
        nreq   = 0;
        waitc  = 0;
        fresh  = 1;
        cpu_req = 1'b1; cpu_write = w; cpu_addr = a; cpu_wdata = d;
        #1;
        for (int c = 0; c < 60 && cpu_stall; c++) begin
            stalls++;
            if (mem_req) begin
                if (fresh) begin
                    if (nreq < 4) begin
                        req_wr[nreq] = mem_write; req_addr[nreq] = mem_addr; req_data[nreq] = mem_wdata;
                    end
                    nreq++;
                    fresh = 0;
                    waitc = 0;
                    if (drop && !mem_write) cpu_req = 1'b0;
                end else begin
                    check("stable_wr", mem_write, req_wr[nreq-1]);
                    check("stable_addr", mem_addr, req_addr[nreq-1]);
                    check("stable_data", mem_wdata, req_data[nreq-1]);
                end
                if (waitc == dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_write ? '0 : mkline(mem_addr);
                    fresh     = 1;
                end
                waitc++;
            end
            tick();
            mem_ack   = 1'b0;
            mem_rdata = '0;
        end
        if (cpu_stall) check("stall_timeout", 1, 0);
        data = cpu_rdata;
        tick();
        cpu_req = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        check("rst_stall", cpu_stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_state", dut.state_q, IDLE);
        rst_n = 1'b1;
        tick();

        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("spur_state", dut.state_q, IDLE);
        check("spur_mem_req", mem_req, 0);

        access(0, 32'h0000_0104, 0, 2, 0, st, rd);
        check("cold_stalls", st, 6);
        check("cold_nreq", nreq, 1);
        check("cold_wr", req_wr[0], 0);
        check("cold_addr", req_addr[0], 32'h0000_0100);
        check("cold_data", rd, 32'hA5A5_0104);

        access(1, 32'h0000_0108, 32'hDEADBEEF, 0, 0, st, rd);
        check("st_hit_stalls", st, 0);
        access(0, 32'h0000_0108, 0, 0, 0, st, rd);
        check("ld_hit_stalls", st, 0);
        check("ld_hit_data", rd, 32'hDEADBEEF);
        check("dirty_set8", dut.u_sram.dirty_q[8], 1);

        access(0, 32'h0000_0308, 0, 1, 0, st, rd);
        check("evict_stalls", st, 7);
        check("evict_nreq", nreq, 2);
        check("wb_wr", req_wr[0], 1);
        check("wb_addr", req_addr[0], 32'h0000_0100);
        check("wb_word2", req_data[0][95:64], 32'hDEADBEEF);
        check("wb_word1", req_data[0][63:32], 32'hA5A5_0104);
        check("rf_wr", req_wr[1], 0);
        check("rf_addr", req_addr[1], 32'h0000_0300);
        check("evict_data", rd, 32'hA5A5_0308);

        access(0, 32'h0000_0404, 0, 1, 1, st, rd);
        check("drop_stalls", st, 5);
        check("drop_state", dut.state_q, IDLE);
        access(0, 32'h0000_0404, 0, 0, 0, st, rd);
        check("drop_rehit_stalls", st, 0);
        check("drop_rehit_data", rd, 32'hA5A5_0404);

        access(0, 32'h0000_005C, 0, 0, 0, st, rd);
        check("clean_stalls", st, 4);
        check("clean_data", rd, 32'hA5A5_005C);

        access(1, 32'h0000_005C, 32'h1234_5678, 0, 0, st, rd);
        check("st2_stalls", st, 0);
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_085C;
        #1;
        n = 0;
        while (!(mem_req && mem_write) && n < 20) begin
            tick();
            n++;
        end
        check("rwb_seen", mem_req && mem_write, 1);
        check("rwb_addr", mem_addr, 32'h0000_0040);
        check("rwb_word7", mem_wdata[255:224], 32'h1234_5678);
        rst_n = 1'b0;
        #1;
        check("rwb_mem_req", mem_req, 0);
        check("rwb_stall", cpu_stall, 0);
        check("rwb_rdata", cpu_rdata, 0);
        check("rwb_state", dut.state_q, IDLE);
        check("rwb_valid", dut.u_sram.valid_q, 0);
        tick();
        rst_n = 1'b1;
        cpu_req = 1'b0;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stray_state", dut.state_q, IDLE);
        check("stray_mem_req", mem_req, 0);
        access(0, 32'h0000_005C, 0, 0, 0, st, rd);
        check("post_rst_stalls", st, 4);
        check("post_rst_data", rd, 32'hA5A5_005C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
